phy_jtag_master: RTL and testbench
==================================

PHY_JTAG_MASTER -- requirements
Module: phy_jtag_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2: clk cycles per TCK half-period; legal range 1..255.
REQ-002 SHALL have parameter MAX_LEN, default 32: maximum shift length in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock.
REQ-004 SHALL have port rstb, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command offer.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when both cmd_valid and cmd_ready are high.
REQ-007 SHALL have port cmd_op, input, 2 bits: 0 TAP_RESET, 1 SHIFT_IR, 2 SHIFT_DR, 3 IDLE_CLOCKS.
REQ-008 SHALL have port cmd_len, input, 6 bits: shift length, or idle period count for IDLE_CLOCKS.
REQ-009 SHALL have port cmd_data, input, MAX_LEN bits: TDI payload, LSB shifted first.
REQ-010 SHALL have port rsp_valid, input/output pair: rsp_valid output 1 bit, rsp_ready input 1 bit.
REQ-011 SHALL have port rsp_data, output, MAX_LEN bits: captured TDO, right-aligned; first bit captured lands in bit 0.
REQ-012 SHALL have ports jtag_tck, jtag_tms, jtag_tdi and jtag_trst_n as 1-bit outputs, and jtag_tdo as a 1-bit input.
REQ-013 SHALL have port busy, output, 1 bit: a command is in progress.

Function
REQ-014 SHALL build each TCK period from 2*TCK_DIV clk cycles: low half first, then high half.
REQ-015 SHALL change TMS and TDI only at the TCK falling edge, and sample TDO in the clk cycle where TCK rises.
REQ-016 SHALL hold TCK low and stop it while idle; no free-running TCK is allowed.
REQ-017 SHALL drive cmd_ready high only when there is no active command and rsp_valid is low.
REQ-018 SHALL produce this TMS sequence for SHIFT_DR (Idle start): 1, 0, 0, then n shift periods with TMS=0 and TMS=1 on the last, then 1, 0.
- Total: n+5 TCK periods, ending in Run-Test/Idle.
REQ-019 SHALL produce the same sequence for SHIFT_IR with one extra leading TMS=1 period, for a total of n+6 periods.
REQ-020 SHALL produce this sequence for TAP_RESET: five TMS=1 periods then one TMS=0 period, 6 periods total, ending in Run-Test/Idle.
REQ-021 SHALL produce, for IDLE_CLOCKS, n periods with TMS=0 and TDI=0.
REQ-022 SHALL treat cmd_len=0 or cmd_len>MAX_LEN as MAX_LEN.
REQ-023 SHALL drive TDI with cmd_data[i] during shift period i, and TDI=0 outside shift periods.
REQ-024 SHALL zero rsp_data bits at and above n.
REQ-025 SHALL assert rsp_valid one clk after the final TCK period completes.
- rsp_data is 0 for TAP_RESET and IDLE_CLOCKS.
REQ-026 SHALL hold rsp_valid and rsp_data stable until rsp_ready is sampled high.
REQ-027 SHALL start the next command's first TCK low half no earlier than the cycle after acceptance.
REQ-028 SHALL follow this internal state machine: IDLE -> WALK_IN -> SHIFT -> WALK_OUT -> RESP -> IDLE.
- TAP_RESET and IDLE_CLOCKS use the WALK_IN/SHIFT path with the TMS patterns above.
- A response is held in RESP until rsp_ready is high.

Reset
REQ-029 SHALL put these outputs in the following state on rstb low at a clk edge:
- jtag_tck=0, jtag_tms=1, jtag_tdi=0, jtag_trst_n=1
- cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0
REQ-030 SHALL assert cmd_ready on the first cycle after rstb returns high.
REQ-031 SHALL, when reset is asserted mid-command, abort the command, drop any response, and force TCK low immediately; the first command after reset is expected to be TAP_RESET.

Configuration
REQ-032 SHALL, with PHY_JTAG_TRST_EN defined, make TAP_RESET also drive jtag_trst_n=0 during the five TMS=1 periods, returning high before the TMS=0 period.
REQ-033 SHALL, without PHY_JTAG_TRST_EN, hold jtag_trst_n constant at 1; TAP_RESET then relies on TMS only.

Structure
REQ-034 SHALL place the following in package phy_jtag_pkg:
- op encoding enum
- state-machine enum
- MAX_LEN default
- TAP_RESET_TMS_LEN=5
REQ-035 SHALL use sub-module phy_jtag_tck_gen: a TCK_DIV divider emitting tck level plus one-cycle fall and rise strobes, gated by a run enable.

Verification
REQ-036 SHALL verify TAP_RESET, TCK_DIV=2:
- Expected TMS sequence: 1,1,1,1,1,0.
- TCK period is 4 clk.
- rsp_valid 1 clk after the 6th period, with rsp_data=0.
REQ-037 SHALL verify SHIFT_IR, len=5, data=5'h12, against a TAP model returning IR capture 5'b00001:
- rsp_data=32'h1.
- TDI observed as 0,1,0,0,1.
- 11 TCK periods.
REQ-038 SHALL verify SHIFT_DR, len=32, data=32'hDEADBEEF, against a model with a 32-bit loopback DR preloaded 32'hCAFEF00D:
- rsp_data=32'hCAFEF00D.
- Model DR = 32'hDEADBEEF after Update.
REQ-039 SHALL verify that cmd_len=0 with SHIFT_DR gives 32 shift periods.
REQ-040 SHALL verify backpressure: rsp_ready held low 20 cycles gives stable rsp_data, cmd_ready=0, and TCK idle low.
REQ-041 SHALL verify rstb pulled low mid-SHIFT_DR at bit 10:
- Next cycle: TCK=0, busy=0, rsp_valid=0.
- With PHY_JTAG_TRST_EN, TAP_RESET shows trst_n low for 5 periods.

Source files
------------

// File: rtl/phy_jtag_pkg.sv
// Shared types and constants for the JTAG master PHY.
package phy_jtag_pkg;

  localparam int unsigned MAX_LEN_DEFAULT   = 32;
  localparam int unsigned TAP_RESET_TMS_LEN = 5;

  typedef enum logic [1:0] {
    OpTapReset   = 2'd0,
    OpShiftIr    = 2'd1,
    OpShiftDr    = 2'd2,
    OpIdleClocks = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWalkIn,
    StShift,
    StWalkOut,
    StResp
  } jtag_state_e;

  // Number of TCK periods spent walking from Run-Test/Idle into the shift state.
  function automatic logic [7:0] walk_in_len(jtag_op_e op);
    unique case (op)
      OpShiftIr:  return 8'd4;
      OpShiftDr:  return 8'd3;
      OpTapReset: return 8'(TAP_RESET_TMS_LEN);
      default:    return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/phy_jtag_tck_gen.sv
// TCK divider: each period is 2*TCK_DIV clk cycles, low half first.
// Strobes are high in the clk cycle *before* the edge at which TCK rises or
// falls, so logic registering on them acts exactly on the TCK edge.
module phy_jtag_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic run_i,
  output logic tck_o,
  output logic fall_o,
  output logic rise_o
);

  localparam logic [8:0] HalfCnt = 9'(TCK_DIV);
  localparam logic [8:0] RiseCnt = 9'(TCK_DIV - 1);
  localparam logic [8:0] LastCnt = 9'(2 * TCK_DIV - 1);

  logic [8:0] cnt_q, cnt_d;

  // Phase counter restarts from the low half whenever the run enable drops.
  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = (cnt_q == LastCnt) ? 9'd0 : cnt_q + 9'd1;
    end
  end

  // Phase counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tck_o  = run_i && (cnt_q >= HalfCnt);
  assign rise_o = run_i && (cnt_q == RiseCnt);
  assign fall_o = run_i && (cnt_q == LastCnt);

endmodule

// File: rtl/phy_jtag_master.sv
// JTAG master PHY: runs TAP reset, IR/DR shifts and idle clocking from a
// valid/ready command stream and returns captured TDO on a response stream.
// Optional feature: define PHY_JTAG_TRST_EN to pulse jtag_trst_n low during
// the TMS=1 phase of TAP_RESET.
module phy_jtag_master import phy_jtag_pkg::*; #(
  parameter int unsigned TCK_DIV = 2,
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  output logic               jtag_trst_n,
  input  logic               jtag_tdo,
  output logic               busy
);

  jtag_state_e        state_q, state_d;
  jtag_op_e           op_q, op_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         k_q, k_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               init_q;

  logic       run, tck_fall, tck_rise, is_shift_op, last_period;
  logic [7:0] len_eff, state_len;

  assign run         = (state_q == StWalkIn) || (state_q == StShift) || (state_q == StWalkOut);
  assign is_shift_op = (op_q == OpShiftIr) || (op_q == OpShiftDr);

  phy_jtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk    (clk),
    .rstb   (rstb),
    .run_i  (run),
    .tck_o  (jtag_tck),
    .fall_o (tck_fall),
    .rise_o (tck_rise)
  );

  // Zero or oversize lengths fall back to a full-width shift.
  always_comb begin
    len_eff = {2'b00, cmd_len};
    if ((cmd_len == 6'd0) || (32'(cmd_len) > MAX_LEN)) begin
      len_eff = 8'(MAX_LEN);
    end
  end

  // Number of TCK periods the current state lasts.
  always_comb begin
    state_len = 8'd0;
    unique case (state_q)
      StWalkIn:  state_len = walk_in_len(op_q);
      StShift:   state_len = (op_q == OpTapReset) ? 8'd1 : len_q;
      StWalkOut: state_len = 8'd2;
      default:   state_len = 8'd0;
    endcase
  end

  assign last_period = (k_q == state_len - 8'd1);

  // TMS/TDI/TRST levels for the current period; they only move at TCK falls.
  always_comb begin
    jtag_tms    = 1'b1;
    jtag_tdi    = 1'b0;
    jtag_trst_n = 1'b1;
    unique case (state_q)
      StWalkIn: begin
        unique case (op_q)
          OpShiftIr: jtag_tms = (k_q < 8'd2);
          OpShiftDr: jtag_tms = (k_q == 8'd0);
          default:   jtag_tms = 1'b1;
        endcase
`ifdef PHY_JTAG_TRST_EN
        jtag_trst_n = (op_q != OpTapReset);
`endif
      end
      StShift: begin
        jtag_tms = is_shift_op && last_period;
        jtag_tdi = is_shift_op && data_q[0];
      end
      StWalkOut: jtag_tms = (k_q == 8'd0);
      default:   jtag_tms = 1'b1;
    endcase
  end

  // Sequencer: accept, walk TAP in, shift, walk out, hold response.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    k_d     = k_q;
    data_d  = data_q;
    cap_d   = cap_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = jtag_op_e'(cmd_op);
          len_d   = len_eff;
          k_d     = 8'd0;
          data_d  = cmd_data;
          cap_d   = '0;
          state_d = (jtag_op_e'(cmd_op) == OpIdleClocks) ? StShift : StWalkIn;
        end
      end
      StWalkIn, StShift, StWalkOut: begin
        if (tck_rise && (state_q == StShift) && is_shift_op) begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (k_q == 8'(i)) cap_d[i] = jtag_tdo;
          end
        end
        if (tck_fall) begin
          if ((state_q == StShift) && is_shift_op) data_d = data_q >> 1;
          if (last_period) begin
            k_d = 8'd0;
            unique case (state_q)
              StWalkIn: state_d = StShift;
              StShift:  state_d = is_shift_op ? StWalkOut : StResp;
              default:  state_d = StResp;
            endcase
          end else begin
            k_d = k_q + 8'd1;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any command and drops the response.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= StIdle;
      op_q    <= OpTapReset;
      len_q   <= '0;
      k_q     <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      k_q     <= k_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      init_q  <= 1'b1;
    end
  end

  assign cmd_ready = init_q && (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = cap_q;
  assign busy      = run;

endmodule

// File: tb/tb_phy_jtag_master.sv
// Directed bench for phy_jtag_master with a behavioural TAP model and a
// response scoreboard. Honours PHY_JTAG_TRST_EN for the TRST expectations.
module tb_phy_jtag_master;

  localparam int unsigned TCK_DIV = 2;
  localparam int unsigned MAX_LEN = 32;
  localparam time         CLK_P   = 10;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [5:0]         cmd_len = 6'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
  logic               jtag_tdo = 1'b0;
  logic               busy;

  always #(CLK_P / 2) clk = ~clk;

  phy_jtag_master #(
    .TCK_DIV (TCK_DIV),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .jtag_tck    (jtag_tck),
    .jtag_tms    (jtag_tms),
    .jtag_tdi    (jtag_tdi),
    .jtag_trst_n (jtag_trst_n),
    .jtag_tdo    (jtag_tdo),
    .busy        (busy)
  );

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPaDr, TapEx2Dr, TapUpDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPaIr, TapEx2Ir, TapUpIr
  } tap_e;

  tap_e        tap_state = TapTlr;
  logic [4:0]  ir_sr = '0, ir_reg = '0;
  logic [31:0] dr_sr = '0, dr_reg = 32'hCAFEF00D;

  function automatic tap_e tap_next(tap_e s, logic tms);
    case (s)
      TapTlr:   return tms ? TapTlr   : TapRti;
      TapRti:   return tms ? TapSelDr : TapRti;
      TapSelDr: return tms ? TapSelIr : TapCapDr;
      TapCapDr: return tms ? TapEx1Dr : TapShDr;
      TapShDr:  return tms ? TapEx1Dr : TapShDr;
      TapEx1Dr: return tms ? TapUpDr  : TapPaDr;
      TapPaDr:  return tms ? TapEx2Dr : TapPaDr;
      TapEx2Dr: return tms ? TapUpDr  : TapShDr;
      TapUpDr:  return tms ? TapSelDr : TapRti;
      TapSelIr: return tms ? TapTlr   : TapCapIr;
      TapCapIr: return tms ? TapEx1Ir : TapShIr;
      TapShIr:  return tms ? TapEx1Ir : TapShIr;
      TapEx1Ir: return tms ? TapUpIr  : TapPaIr;
      TapPaIr:  return tms ? TapEx2Ir : TapPaIr;
      TapEx2Ir: return tms ? TapUpIr  : TapShIr;
      default:  return tms ? TapSelDr : TapRti;
    endcase
  endfunction

  always @(posedge jtag_tck or negedge jtag_trst_n) begin
    if (!jtag_trst_n) begin
      tap_state <= TapTlr;
    end else begin
      case (tap_state)
        TapCapDr: dr_sr  <= dr_reg;
        TapShDr:  dr_sr  <= {jtag_tdi, dr_sr[31:1]};
        TapUpDr:  dr_reg <= dr_sr;
        TapCapIr: ir_sr  <= 5'b00001;
        TapShIr:  ir_sr  <= {jtag_tdi, ir_sr[4:1]};
        TapUpIr:  ir_reg <= ir_sr;
        default: ;
      endcase
      tap_state <= tap_next(tap_state, jtag_tms);
    end
  end

  always @(negedge jtag_tck) begin
    jtag_tdo <= (tap_state == TapShDr) ? dr_sr[0] : (tap_state == TapShIr) ? ir_sr[0] : 1'b0;
  end

  // ---------------- pin monitor ----------------
  bit  tms_log[$];
  bit  tdi_log[$];
  bit  trst_log[$];
  time rise_t[$];

  always @(posedge jtag_tck) begin
    tms_log.push_back(jtag_tms);
    tdi_log.push_back(jtag_tdi);
    trst_log.push_back(jtag_trst_n);
    rise_t.push_back($time);
  end

  function automatic logic [63:0] tms_vec(int start, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) if (start + i < tms_log.size()) v[i] = tms_log[start + i];
    return v;
  endfunction

  function automatic logic [63:0] tdi_vec(int start, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) if (start + i < tdi_log.size()) v[i] = tdi_log[start + i];
    return v;
  endfunction

  function automatic int trst_low_count();
    int c = 0;
    foreach (trst_log[i]) if (!trst_log[i]) c++;
    return c;
  endfunction

  // ---------------- checking ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];
  time         t_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input logic [31:0] exp_rsp, input int hold);
    int n;
    sb.push_back(exp_rsp);
    tms_log.delete();
    tdi_log.delete();
    trst_log.delete();
    rise_t.delete();
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = '0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    t_valid = $time;
    chk("rsp_valid_wait", {63'd0, rsp_valid}, 64'd1);
    // Backpressure: response and idle pins must hold while rsp_ready is low.
    for (int i = 0; i < hold; i++) begin
      chk("hold", {29'd0, rsp_valid, cmd_ready, jtag_tck, rsp_data},
          {29'd0, 1'b1, 1'b0, 1'b0, exp_rsp});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    chk("rsp_data", {32'd0, rsp_data}, {32'd0, sb.pop_front()});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_released", {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    #(CLK_P * 50000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", {60'd0, jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n}, 64'b0101);
    chk("rst_hs", {61'd0, cmd_ready, rsp_valid, busy}, 64'd0);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    rstb = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // TAP_RESET
    run_cmd(2'd0, 6'd0, 32'hFFFF_FFFF, 32'h0, 0);
    chk("rst_periods", rise_t.size(), 6);
    chk("rst_tms", tms_vec(0, 6), 64'h1F);
    chk("tck_period", rise_t[1] - rise_t[0], 2 * TCK_DIV * CLK_P);
    // rsp_valid in the clk cycle following the last TCK high half.
    chk("rsp_latency", t_valid, rise_t[rise_t.size() - 1] + TCK_DIV * CLK_P + 1);
    chk("rst_tap_idle", tap_state, TapRti);
`ifdef PHY_JTAG_TRST_EN
    chk("rst_trst_low", trst_low_count(), 5);
`else
    chk("rst_trst_low", trst_low_count(), 0);
`endif

    // SHIFT_IR len 5
    run_cmd(2'd1, 6'd5, 32'h12, 32'h1, 0);
    chk("ir_periods", rise_t.size(), 11);
    chk("ir_tdi", tdi_vec(4, 5), 64'h12);
    chk("ir_tms", tms_vec(0, 11), 64'h303);
    chk("ir_model", ir_reg, 5'h12);
    chk("ir_tap_idle", tap_state, TapRti);

    // SHIFT_DR len 32 against loopback DR
    run_cmd(2'd2, 6'd32, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
    chk("dr_periods", rise_t.size(), 37);
    chk("dr_model", dr_reg, 32'hDEAD_BEEF);

    // SHIFT_DR len 0 acts as 32
    run_cmd(2'd2, 6'd0, 32'h1234_5678, 32'hDEAD_BEEF, 0);
    chk("dr_len0_periods", rise_t.size(), 37);
    chk("dr_len0_model", dr_reg, 32'h1234_5678);

    // IDLE_CLOCKS len 3
    run_cmd(2'd3, 6'd3, 32'hFFFF_FFFF, 32'h0, 0);
    chk("idle_periods", rise_t.size(), 3);
    chk("idle_tms_tdi", {tms_vec(0, 3)[31:0], tdi_vec(0, 3)[31:0]}, 64'd0);
    chk("idle_tap_idle", tap_state, TapRti);

    // SHIFT_DR len 8 with 20 cycles of backpressure; upper rsp bits zero
    run_cmd(2'd2, 6'd8, 32'hA5, 32'h78, 20);
    chk("dr8_periods", rise_t.size(), 13);
    chk("dr8_model", dr_reg, 32'hA512_3456);

    // Oversize length clamps to MAX_LEN
    run_cmd(2'd2, 6'd40, 32'h0, 32'hA512_3456, 0);
    chk("dr40_periods", rise_t.size(), 37);

    // Reset during SHIFT_DR around bit 10
    rise_t.delete();
    cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = 32'h5555_5555; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (rise_t.size() < 14 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("midrst_reach", {63'd0, busy}, 64'd1);
    rstb = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tck", {63'd0, jtag_tck}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", {63'd0, cmd_ready}, 64'd1);
    run_cmd(2'd0, 6'd0, 32'h0, 32'h0, 0);
    chk("rst2_periods", rise_t.size(), 6);
    chk("rst2_tap_idle", tap_state, TapRti);
`ifdef PHY_JTAG_TRST_EN
    chk("rst2_trst_low", trst_low_count(), 5);
    chk("rst2_trst_last", {63'd0, trst_log[5]}, 64'd1);
`else
    chk("rst2_trst_low", trst_low_count(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
